// File: rtl/riscv_pkg.sv
// Purpose: shared register-file constants, types and a popcount helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int CNT_W      = 6;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] vec);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      acc = acc + CNT_W'(vec[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Purpose: pending-write scoreboard (one busy bit per architectural register).
// Latency: set/clear/flush visible one posedge later; count registered alongside.
// Backpressure: none; every request is accepted each cycle.
// Ports: set_i/set_idx_i mark a register busy, clr_i/clr_idx_i retire it,
//        flush_i drops all marks, busy_o is the vector, cnt_o its popcount.
module regfile_scoreboard
  import riscv_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_i,
  input  reg_addr_t           set_idx_i,
  input  logic                clr_i,
  input  reg_addr_t           clr_idx_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [CNT_W-1:0]    cnt_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    // Clear first so a same-cycle set on the same index wins (newer writer).
    if (clr_i && (clr_idx_i != '0)) busy_d[clr_idx_i] = 1'b0;
    if (set_i && (set_idx_i != '0)) busy_d[set_idx_i] = 1'b1;
    if (flush_i)                     busy_d = '0;
    busy_d[0] = 1'b0;
    // Count tracks the next vector so it is exact right after each edge.
    cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/regfile.sv
// Purpose: 2-read/1-write integer register file with write-first bypass and busy scoreboard.
// Latency: reads combinational (0 cycles); writes and busy updates commit at the next posedge.
// Backpressure: none; writes, issues and flushes are always accepted.
// Ports: reg_write_i/reg_waddr_i/reg_wdata_i writeback; rsN_addr_i -> rsN_data_o/rsN_busy_o;
//        issue_i/issue_rd_i mark a pending writer; flush_i drops marks; pending_cnt_o = busy count.
module regfile
  import riscv_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             reg_write_i,
  input  logic [4:0]       reg_waddr_i,
  input  logic [31:0]      reg_wdata_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  output logic [31:0]      rs1_data_o,
  output logic [31:0]      rs2_data_o,
  input  logic             issue_i,
  input  logic [4:0]       issue_rd_i,
  input  logic             flush_i,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  output logic [5:0]       pending_cnt_o
);

  xlen_t               regs_q [NUM_REGS-1:1];
  xlen_t               regs_d [NUM_REGS-1:1];
  logic [NUM_REGS-1:0] busy_vec;
  logic                wr_en;

  reg_addr_t rd_addr [2];
  xlen_t     rd_data [2];
  logic      rd_busy [2];

  assign wr_en      = reg_write_i && (reg_waddr_i != '0);
  assign rd_addr[0] = rs1_addr_i;
  assign rd_addr[1] = rs2_addr_i;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[reg_waddr_i] = reg_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      // Reset gating keeps the bypass path from leaking wdata while held in reset.
      if (rst_i && (rd_addr[p] != '0)) begin
        if (wr_en && (reg_waddr_i == rd_addr[p])) begin
          rd_data[p] = reg_wdata_i;
          // The writeback retires the mark, unless a newer writer issues now.
          rd_busy[p] = issue_i && (issue_rd_i == rd_addr[p]) && busy_vec[rd_addr[p]];
        end else begin
          rd_data[p] = regs_q[rd_addr[p]];
          rd_busy[p] = busy_vec[rd_addr[p]];
        end
      end
    end
  end

  assign rs1_data_o = rd_data[0];
  assign rs2_data_o = rd_data[1];
  assign rs1_busy_o = rd_busy[0];
  assign rs2_busy_o = rd_busy[1];

  regfile_scoreboard u_scoreboard (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_i     (issue_i),
    .set_idx_i (issue_rd_i),
    .clr_i     (reg_write_i),
    .clr_idx_i (reg_waddr_i),
    .flush_i   (flush_i),
    .busy_o    (busy_vec),
    .cnt_o     (pending_cnt_o)
  );

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic [4:0]  rs1_addr_i = '0;
  logic [4:0]  rs2_addr_i = '0;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        issue_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic        flush_i = 1'b0;
  logic        rs1_busy_o, rs2_busy_o;
  logic [5:0]  pending_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Architectural model: plain arrays of register values and pending flags.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  regfile dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_write_i(reg_write_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i), .flush_i(flush_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .pending_cnt_o(pending_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!rst_i || a == 0) return '0;
    if (reg_write_i && reg_waddr_i == a) return reg_wdata_i;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst_i || a == 0) return 1'b0;
    if (reg_write_i && reg_waddr_i == a && !(issue_i && issue_rd_i == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    if (!rst_i) return 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Model state advances on each active edge, or clears on reset.
  always @(negedge rst_i) model_clear();

  always @(posedge clk_i) begin
    if (!rst_i) begin
      model_clear();
    end else begin
      if (reg_write_i && reg_waddr_i != 0) begin
        m_regs[reg_waddr_i] = reg_wdata_i;
        m_busy[reg_waddr_i] = 1'b0;
      end
      if (issue_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
      if (flush_i) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end
  end

  // Single compare process, mid-cycle.
  always @(negedge clk_i) begin
    if (chk_on) begin
      check("rs1_data", rs1_data_o, exp_data(rs1_addr_i));
      check("rs2_data", rs2_data_o, exp_data(rs2_addr_i));
      check("rs1_busy", 32'(rs1_busy_o), 32'(exp_busy(rs1_addr_i)));
      check("rs2_busy", 32'(rs2_busy_o), 32'(exp_busy(rs2_addr_i)));
      check("pending_cnt", 32'(pending_cnt_o), 32'(exp_cnt()));
    end
  end

  // Apply one cycle of inputs just after a posedge, return mid-cycle.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input logic iss, input logic [4:0] ird, input logic fl);
    @(posedge clk_i);
    #1;
    reg_write_i = we; reg_waddr_i = wa; reg_wdata_i = wd;
    rs1_addr_i = a1; rs2_addr_i = a2;
    issue_i = iss; issue_rd_i = ird; flush_i = fl;
    @(negedge clk_i);
    #1;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cyc(1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    model_clear();
    chk_on = 1'b1;
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;

    // Reset state on every index, both ports.
    for (int a = 0; a < 32; a++) begin
      idle(5'(a), 5'(31 - a));
      check("rst_rs1_data", rs1_data_o, 32'd0);
      check("rst_rs2_data", rs2_data_o, 32'd0);
      check("rst_rs1_busy", 32'(rs1_busy_o), 32'd0);
      check("rst_rs2_busy", 32'(rs2_busy_o), 32'd0);
      check("rst_cnt", 32'(pending_cnt_o), 32'd0);
    end

    // Bypass then committed value.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
    check("x5_bypass", rs1_data_o, 32'hDEADBEEF);
    check("x5_bypass_p2", rs2_data_o, 32'hDEADBEEF);
    idle(5'd5, 5'd0);
    check("x5_stored", rs1_data_o, 32'hDEADBEEF);

    // x0 ignores writes and issues.
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    check("x0_data", rs1_data_o, 32'd0);
    check("x0_busy", 32'(rs1_busy_o), 32'd0);
    idle(5'd0, 5'd0);
    check("x0_data_after", rs1_data_o, 32'd0);
    check("x0_cnt", 32'(pending_cnt_o), 32'd0);

    // Same-cycle set and clear: newer writer keeps it busy.
    cyc(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
    cyc(1'b1, 5'd7, 32'h77, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
    check("x7_busy_reissue", 32'(rs1_busy_o), 32'd1);
    check("x7_cnt_1", 32'(pending_cnt_o), 32'd1);
    cyc(1'b1, 5'd7, 32'h78, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    check("x7_cnt_still1", 32'(pending_cnt_o), 32'd1);
    check("x7_busy_bypassed", 32'(rs1_busy_o), 32'd0);
    idle(5'd7, 5'd7);
    check("x7_busy_clear", 32'(rs1_busy_o), 32'd0);
    check("x7_cnt_0", 32'(pending_cnt_o), 32'd0);
    check("x7_data", rs1_data_o, 32'h78);

    // Flush overrides same-cycle issue.
    cyc(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd4, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd9, 1'b0);
    check("cnt_before_9", 32'(pending_cnt_o), 32'd2);
    cyc(1'b0, 5'd0, 32'd0, 5'd3, 5'd10, 1'b1, 5'd10, 1'b1);
    check("cnt_pre_flush", 32'(pending_cnt_o), 32'd3);
    check("x3_busy_pre_flush", 32'(rs1_busy_o), 32'd1);
    idle(5'd10, 5'd9);
    check("cnt_post_flush", 32'(pending_cnt_o), 32'd0);
    check("x10_busy_post_flush", 32'(rs1_busy_o), 32'd0);
    check("x9_busy_post_flush", 32'(rs2_busy_o), 32'd0);

    // Asynchronous reset mid-cycle, then first edge after release.
    cyc(1'b1, 5'd12, 32'h1234, 5'd12, 5'd12, 1'b1, 5'd13, 1'b0);
    idle(5'd12, 5'd13);
    check("x12_stored", rs1_data_o, 32'h1234);
    check("x13_busy", 32'(rs2_busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("x12_async_rst", rs1_data_o, 32'd0);
    check("x13_async_rst_busy", 32'(rs2_busy_o), 32'd0);
    check("cnt_async_rst", 32'(pending_cnt_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    cyc(1'b1, 5'd12, 32'h55, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle(5'd12, 5'd5);
    check("x12_post_rst", rs1_data_o, 32'h55);
    check("x5_post_rst", rs2_data_o, 32'd0);

    // Randomized traffic; small hot set of addresses for frequent collisions.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wa, a1, a2, ird;
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      a1  = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 7));
      ird = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 1)), wa, $urandom, a1, a2,
          1'($urandom_range(0, 1)), ird, ($urandom_range(0, 23) == 0));
    end

    idle(5'd0, 5'd0);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have ports: rst_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: reg_write_i  in  1  writeback write enable.
REQ-004 SHALL have ports: reg_waddr_i  in  5  writeback destination index.
REQ-005 SHALL have ports: reg_wdata_i  in  32  writeback data.
REQ-006 SHALL have ports: rs1_addr_i, rs2_addr_i  in  5 each  read port indices.
REQ-007 SHALL have ports: rs1_data_o, rs2_data_o  out  32 each  read port data.
REQ-008 SHALL have ports: issue_i  in  1  decode issues an instruction that will write rd.
REQ-009 SHALL have ports: issue_rd_i  in  5  destination of issued instruction.
REQ-010 SHALL have ports: flush_i  in  1  pipeline flush; discard all pending-write marks.
REQ-011 SHALL have ports: rs1_busy_o, rs2_busy_o  out  1 each  read index has a pending write.
REQ-012 SHALL have ports: pending_cnt_o  out  6  number of registers currently marked busy (0..31).

Function
REQ-013 Storage SHALL be 31 x 32-bit registers x1..x31; x0 SHALL read 0 always and ignore writes.
REQ-014 Write SHALL commit at posedge when reg_write_i=1 and reg_waddr_i!=0; one-cycle write latency.
REQ-015 Reads SHALL be combinational, zero latency, from current register contents.
REQ-016 Write-first bypass: when reg_write_i=1, reg_waddr_i!=0 and reg_waddr_i==rsN_addr_i, rsN_data_o SHALL equal reg_wdata_i in the same cycle.
REQ-017 Both read ports SHALL be independent; identical addresses on both SHALL return identical data.
REQ-018 Scoreboard: busy[32] bit vector; issue_i=1 with issue_rd_i!=0 SHALL set busy[issue_rd_i] at posedge.
REQ-019 reg_write_i=1 with reg_waddr_i!=0 SHALL clear busy[reg_waddr_i] at posedge.
REQ-020 Simultaneous set and clear on same index SHALL leave busy=1 (newer writer wins).
REQ-021 Set on index already busy SHALL leave busy=1 (no error, no count change).
REQ-022 Clear on index not busy SHALL be harmless (busy stays 0, count unchanged).
REQ-023 busy[0] SHALL be constant 0; rsN_busy_o SHALL be 0 for index 0.
REQ-024 rsN_busy_o SHALL be busy[rsN_addr_i] masked by same-cycle bypass: if REQ-016 bypass applies to port N, rsN_busy_o SHALL be 0 unless issue_i also targets that index (then prior value).
REQ-025 flush_i=1 SHALL clear all busy bits at posedge, overriding same-cycle issue; register writes in that cycle SHALL still commit.
REQ-026 pending_cnt_o SHALL be registered and always equal popcount(busy) after each edge; saturation not needed (max 31).

Reset
REQ-027 rst_i=0 SHALL asynchronously clear all registers x1..x31 to 0, all busy bits to 0, pending_cnt_o to 0.
REQ-028 During reset rsN_data_o SHALL read 0 and rsN_busy_o SHALL be 0; writes and issues SHALL be ignored.
REQ-029 Reset deassertion SHALL be usable on the next posedge; a write presented on that edge SHALL commit.

Structure
REQ-030 riscv_pkg SHALL hold NUM_REGS=32, REG_ADDR_W=5, XLEN=32 and typedef reg_addr_t.
REQ-031 Scoreboard (busy vector, set/clear/flush, count) SHALL be sub-module regfile_scoreboard; storage and bypass stay in regfile.

Verification
REQ-032 Reset, then read all 32 indices on both ports -> every data 0, every busy 0, pending_cnt_o=0.
REQ-033 Write x5=0xDEADBEEF while rs1_addr_i=5 -> rs1_data_o=0xDEADBEEF same cycle; next cycle with reg_write_i=0 still 0xDEADBEEF.
REQ-034 Write x0=0xFFFFFFFF, issue rd=0 -> rs1_data_o(0)=0, rs1_busy_o=0, pending_cnt_o=0.
REQ-035 Issue rd=7, next cycle issue rd=7 while writeback x7 -> busy[7]=1, pending_cnt_o=1; then writeback x7 alone -> busy 0, count 0.
REQ-036 Issue rd=3,4,9 on consecutive cycles, then flush_i with issue rd=10 -> all busy 0, pending_cnt_o=0 after flush edge.
REQ-037 Write x12=0x1234, assert rst_i=0 mid-cycle -> x12 reads 0 immediately, no posedge required.
